// File: rtl/grade_pkg.sv
`default_nettype none
// ============================================================================
// Module   : grade_pkg
// Purpose  : Shared widths, constants, state codes and score saturation helper
//            for the grade accumulator.
// Revision : 1.0 - initial release
// ============================================================================
package grade_pkg;

    localparam int GRADE_W           = 4;
    localparam int SUM_W             = 7;
    localparam int SCORE_W           = 5;
    localparam int COUNT_W           = 3;
    localparam int DIVISOR           = 10;
    localparam int MAX_SCORE_DEFAULT = 25;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_ACCUM  = 2'd1;
    localparam state_t ST_DIVIDE = 2'd2;
    localparam state_t ST_DONE   = 2'd3;

    function automatic logic [SUM_W-1:0] sat_score(input logic [SCORE_W-1:0] score,
                                                   input logic [SCORE_W-1:0] ceiling);
        return (score > ceiling) ? SUM_W'(ceiling) : SUM_W'(score);
    endfunction

endpackage
`default_nettype wire

// File: rtl/grade_accumulator_if.sv
`default_nettype none
// ============================================================================
// Module   : grade_accumulator_if
// Purpose  : Score entry strobe/clear and grade code outputs of the accumulator.
// Revision : 1.0 - initial release
// ============================================================================
interface grade_accumulator_if;
    import grade_pkg::*;

    logic                clear;
    logic                score_valid;
    logic [SCORE_W-1:0]  score_in;
    logic                a;
    logic                b;
    logic                c;
    logic                d;
    logic                ready;
    logic                busy;
    logic [COUNT_W-1:0]  count;

    modport master (
        output clear, score_valid, score_in,
        input  a, b, c, d, ready, busy, count
    );

    modport slave (
        input  clear, score_valid, score_in,
        output a, b, c, d, ready, busy, count
    );

endinterface
`default_nettype wire

// File: rtl/div10_seq.sv
`default_nettype none
// ============================================================================
// Module   : div10_seq
// Purpose  : Sequential divide-by-ten by repeated subtraction, one step/cycle.
// Revision : 1.0 - initial release
// ============================================================================
module div10_seq
    import grade_pkg::*;
(
    input  wire logic               clk,
    input  wire logic               reset,
    input  wire logic               start,
    input  wire logic [SUM_W-1:0]   dividend,
    output logic                    done,
    output logic [GRADE_W-1:0]      quotient
);

    logic               r_active;
    logic [SUM_W-1:0]   r_rem;
    logic [GRADE_W-1:0] r_q;

    // start always reloads, so a run orphaned by an abort is simply overwritten
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_active <= 1'b0;
            r_rem    <= '0;
            r_q      <= '0;
        end else if (start) begin
            r_active <= 1'b1;
            r_rem    <= dividend;
            r_q      <= '0;
        end else if (r_active) begin
            if (r_rem >= SUM_W'(DIVISOR)) begin
                r_rem <= r_rem - SUM_W'(DIVISOR);
                r_q   <= r_q + GRADE_W'(1);
            end else begin
                r_active <= 1'b0;
            end
        end
    end

    // masked during start so a stale run cannot finish a freshly requested one
    assign done     = r_active && !start && (r_rem < SUM_W'(DIVISOR));
    assign quotient = r_q;

endmodule
`default_nettype wire

// File: rtl/grade_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : grade_accumulator
// Purpose  : Sums N_ITEMS saturated partial scores and presents sum/10 as a
//            4-bit grade code with a level ready for the display decoder.
// Revision : 1.0 - initial release
// ============================================================================
module grade_accumulator
    import grade_pkg::*;
#(
    parameter int N_ITEMS   = 4,
    parameter int MAX_SCORE = MAX_SCORE_DEFAULT
) (
    input  wire logic           clk,
    input  wire logic           reset,
    grade_accumulator_if.slave  bus
);

    localparam logic [COUNT_W-1:0] c_n_items   = COUNT_W'(N_ITEMS);
    localparam logic [SCORE_W-1:0] c_max_score = SCORE_W'(MAX_SCORE);

    state_t             r_state;
    logic [SUM_W-1:0]   r_sum;
    logic [COUNT_W-1:0] r_count;
    logic [GRADE_W-1:0] r_code;
    logic               r_ready;
    logic               r_start;

    logic [SUM_W-1:0]   w_score;
    logic [SUM_W-1:0]   w_sum_acc;
    logic [COUNT_W-1:0] w_count_inc;
    logic               w_div_done;
    logic [GRADE_W-1:0] w_quotient;

    assign w_score     = sat_score(bus.score_in, c_max_score);
    assign w_sum_acc   = r_sum + w_score;
    assign w_count_inc = r_count + COUNT_W'(1);

    div10_seq u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (r_start),
        .dividend (r_sum),
        .done     (w_div_done),
        .quotient (w_quotient)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_sum   <= '0;
            r_count <= '0;
            r_code  <= '0;
            r_ready <= 1'b0;
            r_start <= 1'b0;
        end else begin
            r_start <= 1'b0;
            if (bus.clear) begin
                r_state <= ST_IDLE;
                r_sum   <= '0;
                r_count <= '0;
                r_code  <= '0;
                r_ready <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE, ST_DONE: begin
                        // code is left untouched here; only ready drops
                        if (bus.score_valid) begin
                            r_sum   <= w_score;
                            r_count <= COUNT_W'(1);
                            r_ready <= 1'b0;
                            if (N_ITEMS == 1) begin
                                r_state <= ST_DIVIDE;
                                r_start <= 1'b1;
                            end else begin
                                r_state <= ST_ACCUM;
                            end
                        end
                    end
                    ST_ACCUM: begin
                        if (bus.score_valid) begin
                            r_sum   <= w_sum_acc;
                            r_count <= w_count_inc;
                            if (w_count_inc == c_n_items) begin
                                r_state <= ST_DIVIDE;
                                r_start <= 1'b1;
                            end
                        end
                    end
                    ST_DIVIDE: begin
                        if (w_div_done) begin
                            r_code  <= w_quotient;
                            r_ready <= 1'b1;
                            r_state <= ST_DONE;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.a     = r_code[3];
    assign bus.b     = r_code[2];
    assign bus.c     = r_code[1];
    assign bus.d     = r_code[0];
    assign bus.ready = r_ready;
    assign bus.busy  = (r_state == ST_ACCUM) || (r_state == ST_DIVIDE);
    assign bus.count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_grade_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_grade_accumulator
// Purpose  : Scoreboard bench: reference model predicts grade and ready edge,
//            a negedge monitor compares whenever ready rises.
// Revision : 1.0 - initial release
// ============================================================================
module tb_grade_accumulator;

    localparam int N    = 4;
    localparam int MAXS = 25;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    grade_accumulator_if bus();

    grade_accumulator #(.N_ITEMS(N), .MAX_SCORE(MAXS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int     grade;
        longint at_edge;
    } exp_t;

    exp_t   exp_q[$];
    int     items[$];
    int     m_count     = 0;
    bit     have_result = 1'b0;
    longint div_start   = -1;
    longint div_end     = -1;
    int     last_grade  = 0;
    bit     prev_ready  = 1'b0;

    logic [3:0] code;
    assign code = {bus.a, bus.b, bus.c, bus.d};

    function automatic void chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // Monitor: pops the scoreboard on every rising ready
    always @(negedge clk) begin
        if (reset) begin
            prev_ready = 1'b0;
        end else begin
            if (bus.ready && !prev_ready) begin
                chk("ready_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("grade", code, e.grade);
                    chk("ready_edge", cyc, e.at_edge);
                    last_grade = e.grade;
                end
            end else if (bus.ready) begin
                chk("code_hold", code, last_grade);
            end
            prev_ready = bus.ready;
        end
    end

    // One cycle of stimulus; the reference model decides acceptance from edge timing
    task automatic step(input bit v, input int s, input bit c);
        longint t;
        int     sum;
        int     g;
        @(negedge clk);
        bus.score_valid = v;
        bus.score_in    = 5'(s);
        bus.clear       = c;
        t = cyc + 1;
        if (c) begin
            if (t <= div_end && exp_q.size() > 0 && exp_q[$].at_edge == div_end)
                void'(exp_q.pop_back());
            div_end     = t;
            items.delete();
            m_count     = 0;
            have_result = 1'b0;
        end else if (v && t > div_end) begin
            if (items.size() == 0) have_result = 1'b0;
            items.push_back((s > MAXS) ? MAXS : s);
            m_count = items.size();
            if (items.size() == N) begin
                sum = 0;
                foreach (items[i]) sum += items[i];
                g           = sum / 10;
                div_start   = t;
                div_end     = t + g + 2;
                exp_q.push_back('{g, div_end});
                items.delete();
                have_result = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        chk("count", bus.count, m_count);
        chk("busy", bus.busy, (items.size() > 0) || (t >= div_start && t < div_end));
        chk("ready", bus.ready, have_result && t >= div_end);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0);
    endtask

    task automatic send4(input int s0, input int s1, input int s2, input int s3);
        step(1'b1, s0, 1'b0);
        step(1'b1, s1, 1'b0);
        step(1'b1, s2, 1'b0);
        step(1'b1, s3, 1'b0);
    endtask

    // Asynchronous reset in the middle of a cycle, checked before any clock edge
    task automatic reset_mid();
        @(negedge clk);
        bus.score_valid = 1'b0;
        bus.clear       = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("rst_code", code, 0);
        chk("rst_ready", bus.ready, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_count", bus.count, 0);
        exp_q.delete();
        items.delete();
        m_count     = 0;
        have_result = 1'b0;
        div_start   = -1;
        div_end     = cyc;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int r;
        int wait_cycles;
        bus.clear       = 1'b0;
        bus.score_valid = 1'b0;
        bus.score_in    = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("init_code", code, 0);
        chk("init_ready", bus.ready, 0);
        chk("init_busy", bus.busy, 0);
        chk("init_count", bus.count, 0);
        @(negedge clk);
        reset = 1'b0;
        div_end = cyc;

        // abort mid-divide
        send4(25, 25, 25, 20);
        idle(3);
        reset_mid();
        idle(2);

        // sum 75 -> 7, held until next strobe
        send4(20, 18, 22, 15);
        idle(12);
        // saturation to 100 -> 10
        send4(31, 30, 25, 29);
        idle(14);
        // minimum latency and truncation
        send4(9, 0, 0, 0);
        idle(4);
        send4(25, 25, 25, 24);
        idle(13);
        // clear with third strobe
        step(1'b1, 10, 1'b0);
        step(1'b1, 10, 1'b0);
        step(1'b1, 7, 1'b1);
        send4(10, 10, 10, 10);
        idle(8);
        // strobe during divide dropped, strobe in done restarts
        send4(20, 20, 20, 20);
        step(1'b1, 5, 1'b0);
        idle(12);
        step(1'b1, 3, 1'b0);
        step(1'b1, 3, 1'b0);
        step(1'b1, 3, 1'b0);
        step(1'b1, 3, 1'b0);
        idle(5);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 99);
            if (r < 3)       step(1'($urandom_range(0, 1)), $urandom_range(0, 31), 1'b1);
            else if (r < 60) step(1'b1, $urandom_range(0, 31), 1'b0);
            else             step(1'b0, 0, 1'b0);
        end

        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 50) begin
            idle(1);
            wait_cycles++;
        end
        chk("drain", exp_q.size(), 0);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/grade_accumulator.md
# grade_accumulator

Upstream stage for the seven-segment grade display decoder. Collects a fixed number of partial scores from the entry logic and sums them. It converts the total to a 0–10 grade by sequential division by 10. It then presents the grade as the 4-bit code `{a,b,c,d}` with a level `ready`, which the decoder consumes directly.

## Interface
- `N_ITEMS`, default 4: number of partial scores per grade (1..4).
- `MAX_SCORE`, default 25: per-item ceiling. Larger inputs saturate to this value.
- `clk`  in  1: rising-edge clock.
- `reset`  in  1: asynchronous, active-high reset. The only clock and the only reset.
- `clear`  in  1: synchronous abort/restart; returns to IDLE.
- `score_valid`  in  1: one-cycle strobe qualifying `score_in`.
- `score_in`  in  5: partial score, unsigned 0..31.
- `a`, `b`, `c`, `d`  out  1 each: grade code. `a` is the MSB, `d` is the LSB. Value 0..10.
- `ready`  out  1: grade code valid. Level signal, wired to the decoder `ready`.
- `busy`  out  1: high in ACCUM and DIVIDE.
- `count`  out  3: number of scores accepted in the current grade.

## Operation
- Internal registers:
  - `sum`: 7 bits, maximum 4×25 = 100.
  - `rem`: 7 bits.
  - `q`: 4 bits.
- States:
  - IDLE: waiting for the first score.
  - ACCUM: collecting scores.
  - DIVIDE: computing the quotient.
  - DONE: result held on the outputs.
- Score acceptance:
  - Accepted in IDLE, ACCUM and DONE when `score_valid`=1.
  - Value added is `min(score_in, MAX_SCORE)`.
  - IDLE or DONE plus `score_valid`: `sum`←score, `count`←1, `ready`←0, next state ACCUM. If `N_ITEMS`=1, next state is DIVIDE instead.
  - ACCUM plus `score_valid`: `sum`+=score, `count`+=1. When the new `count` equals `N_ITEMS`: `rem`←new sum, `q`←0, next state DIVIDE.
- DIVIDE runs one step per cycle:
  - If `rem` ≥ 10: `rem`−=10 and `q`+=1.
  - Otherwise: `{a,b,c,d}`←`q`, `ready`←1, next state DONE.
  - The result truncates: sum 99 gives grade 9, sum 100 gives grade 10.
- `score_valid` during DIVIDE is ignored and dropped. `count` does not change.
- DONE holds `{a,b,c,d}` and `ready`=1 until a new `score_valid` or `clear`.
- `clear` sends any state to IDLE: `sum`=0, `count`=0, `ready`=0, code=0.
  - `clear` has priority over a simultaneous `score_valid`. That score is dropped.
- Grade code changes only on the DIVIDE→DONE transition and on clear/reset. It never toggles while `ready`=1.

## Timing
- Reset values: `a`=`b`=`c`=`d`=0, `ready`=0, `busy`=0, `count`=0, state IDLE. Internal `sum`, `rem` and `q` are 0.
- Reset mid-operation, in any state, aborts immediately and asynchronously. No partial result is ever presented.
- All outputs are registered. No combinational path from inputs to outputs.
- Latency from the edge accepting the last score to `ready`=1 is q+2 cycles for grade q:
  - one cycle entering DIVIDE;
  - q subtract cycles;
  - one cycle of final compare and output load.
- Worst case is grade 10: 12 cycles.
- Back-to-back strobes are legal in ACCUM, one score per cycle.
- A strobe in the same cycle as the DONE→ACCUM restart is accepted as item 1.

## Structure
- Shared package `grade_pkg` holds:
  - the state enum (IDLE, ACCUM, DIVIDE, DONE);
  - `GRADE_W`=4, `SUM_W`=7, `DIVISOR`=10 and the `MAX_SCORE` default.
- One sub-module, `div10_seq`: the sequential repeated-subtraction divider.
  - Ports: start, dividend[6:0], done, quotient[3:0].
  - The top-level FSM keeps control of states and handshakes.

## Test plan
- Reset asserted mid-DIVIDE after scores 25,25,25,20 → outputs zero immediately, `ready`=0. After release, the block is in IDLE with `count`=0.
- Scores 20,18,22,15 (sum 75) → `{a,b,c,d}`=0111 and `ready`=1 exactly 9 cycles after the 4th strobe edge. Held until the next strobe.
- Scores 31,30,25,29 → saturate to sum 100. Result is 1010 after 12 cycles, `busy` high throughout.
- Scores 9,0,0,0 → grade 0000 after 2 cycles. Scores 25,25,25,24 (sum 99) → 1001, confirming truncation.
- `clear` together with the 3rd `score_valid` → IDLE, `count`=0, score dropped. The next 4 scores 10,10,10,10 → grade 0100.
- Strobe during DIVIDE is ignored, final grade unchanged. A strobe while in DONE drops `ready` the next cycle and sets `count`=1.
